// File: rtl/time_set_ctrl.sv
// Set-mode controller: button-driven edit of hour/minute/second with wrap and
// auto-repeat, committed to the counter chain through a stretched set strobe.
module time_set_ctrl #(
  parameter int unsigned HOUR_MAX      = 23,
  parameter int unsigned MIN_MAX       = 59,
  parameter int unsigned SEC_MAX       = 59,
  parameter int unsigned HOLD_CYCLES   = 500,
  parameter int unsigned REPEAT_CYCLES = 100,
  parameter int unsigned SET_LEN       = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_cancel,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_minute,
  input  logic [5:0] cur_second,
  output logic [4:0] set_hour,
  output logic [5:0] set_minute,
  output logic [5:0] set_second,
  output logic       set,
  output logic       editing,
  output logic [1:0] field_sel
);

  typedef enum logic [2:0] {S_RUN, S_EDIT_H, S_EDIT_M, S_EDIT_S, S_COMMIT} state_t;

  localparam int unsigned CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int RW = $clog2(CNT_MAX + 1);
  localparam int SW = $clog2(SET_LEN + 1);
  localparam logic [RW-1:0] HOLD_CNT = RW'(HOLD_CYCLES);
  localparam logic [RW-1:0] REP_CNT  = RW'(REPEAT_CYCLES);
  localparam logic [SW-1:0] SET_LAST = SW'(SET_LEN - 1);

  state_t        r_state, w_state_nxt;
  logic [4:0]    r_set_hour, w_hour_nxt;
  logic [5:0]    r_set_minute, w_minute_nxt;
  logic [5:0]    r_set_second, w_second_nxt;
  logic          r_set, r_editing;
  logic [1:0]    r_field_sel, w_field_sel_nxt;
  logic          r_prev_mode, r_prev_cancel, r_prev_inc, r_prev_dec;
  logic [RW-1:0] r_rep_cnt, w_rep_cnt_nxt;
  logic          r_rep_phase, w_rep_phase_nxt;
  logic [SW-1:0] r_set_cnt, w_set_cnt_nxt;
  logic          w_step;

  logic w_ev_mode, w_ev_cancel, w_ev_inc, w_ev_dec;
  assign w_ev_mode   = btn_mode   & ~r_prev_mode;
  assign w_ev_cancel = btn_cancel & ~r_prev_cancel;
  assign w_ev_inc    = btn_inc    & ~r_prev_inc;
  assign w_ev_dec    = btn_dec    & ~r_prev_dec;

  // Out-of-range (corrupt) captures go to 0 on inc and to MAX on dec.
  function automatic logic [6:0] wrap_step(input logic [6:0] v, input logic [6:0] mx,
                                           input logic up);
    if (up) return (v >= mx) ? 7'd0 : v + 7'd1;
    else    return (v == 7'd0 || v > mx) ? mx : v - 7'd1;
  endfunction

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt     = r_state;
    w_hour_nxt      = r_set_hour;
    w_minute_nxt    = r_set_minute;
    w_second_nxt    = r_set_second;
    w_rep_cnt_nxt   = r_rep_cnt;
    w_rep_phase_nxt = r_rep_phase;
    w_set_cnt_nxt   = r_set_cnt;
    w_step          = 1'b0;
    w_field_sel_nxt = 2'd0;

    unique case (r_state)
      S_RUN: begin
        w_rep_cnt_nxt   = '0;
        w_rep_phase_nxt = 1'b0;
        if (w_ev_mode) begin
          w_hour_nxt   = cur_hour;
          w_minute_nxt = cur_minute;
          w_second_nxt = cur_second;
          w_state_nxt  = S_EDIT_H;
        end
      end
      S_EDIT_H, S_EDIT_M, S_EDIT_S: begin
        if (w_ev_cancel) begin
          w_state_nxt     = S_RUN;
          w_rep_cnt_nxt   = '0;
          w_rep_phase_nxt = 1'b0;
        end else if (w_ev_mode) begin
          w_state_nxt     = (r_state == S_EDIT_H) ? S_EDIT_M :
                            (r_state == S_EDIT_M) ? S_EDIT_S : S_COMMIT;
          w_rep_cnt_nxt   = '0;
          w_rep_phase_nxt = 1'b0;
          w_set_cnt_nxt   = '0;
        end else if (btn_inc == btn_dec) begin
          w_rep_cnt_nxt   = '0;
          w_rep_phase_nxt = 1'b0;
        end else if (w_ev_inc || w_ev_dec) begin
          w_step          = 1'b1;
          w_rep_cnt_nxt   = RW'(1);
          w_rep_phase_nxt = 1'b0;
        end else if (r_rep_cnt != '0) begin
          // Zero count means "not armed": a level held over from a field change never repeats.
          if ((!r_rep_phase && r_rep_cnt == HOLD_CNT) || (r_rep_phase && r_rep_cnt == REP_CNT)) begin
            w_step          = 1'b1;
            w_rep_cnt_nxt   = RW'(1);
            w_rep_phase_nxt = 1'b1;
          end else begin
            w_rep_cnt_nxt = r_rep_cnt + RW'(1);
          end
        end
      end
      S_COMMIT: begin
        w_rep_cnt_nxt   = '0;
        w_rep_phase_nxt = 1'b0;
        if (r_set_cnt == SET_LAST) w_state_nxt = S_RUN;
        else                       w_set_cnt_nxt = r_set_cnt + SW'(1);
      end
      default: w_state_nxt = S_RUN;
    endcase

    if (w_step) begin
      unique case (r_state)
        S_EDIT_H: w_hour_nxt   = 5'(wrap_step({2'b00, r_set_hour}, 7'(HOUR_MAX), btn_inc));
        S_EDIT_M: w_minute_nxt = 6'(wrap_step({1'b0, r_set_minute}, 7'(MIN_MAX), btn_inc));
        S_EDIT_S: w_second_nxt = 6'(wrap_step({1'b0, r_set_second}, 7'(SEC_MAX), btn_inc));
        default: ;
      endcase
    end

    unique case (w_state_nxt)
      S_EDIT_H: w_field_sel_nxt = 2'd1;
      S_EDIT_M: w_field_sel_nxt = 2'd2;
      S_EDIT_S: w_field_sel_nxt = 2'd3;
      default:  w_field_sel_nxt = 2'd0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_RUN;
      r_set_hour    <= '0;
      r_set_minute  <= '0;
      r_set_second  <= '0;
      r_set         <= 1'b0;
      r_editing     <= 1'b0;
      r_field_sel   <= 2'd0;
      r_prev_mode   <= 1'b0;
      r_prev_cancel <= 1'b0;
      r_prev_inc    <= 1'b0;
      r_prev_dec    <= 1'b0;
      r_rep_cnt     <= '0;
      r_rep_phase   <= 1'b0;
      r_set_cnt     <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_set_hour    <= w_hour_nxt;
      r_set_minute  <= w_minute_nxt;
      r_set_second  <= w_second_nxt;
      r_set         <= (w_state_nxt == S_COMMIT);
      r_editing     <= (w_field_sel_nxt != 2'd0);
      r_field_sel   <= w_field_sel_nxt;
      r_prev_mode   <= btn_mode;
      r_prev_cancel <= btn_cancel;
      r_prev_inc    <= btn_inc;
      r_prev_dec    <= btn_dec;
      r_rep_cnt     <= w_rep_cnt_nxt;
      r_rep_phase   <= w_rep_phase_nxt;
      r_set_cnt     <= w_set_cnt_nxt;
    end
  end

  assign set_hour   = r_set_hour;
  assign set_minute = r_set_minute;
  assign set_second = r_set_second;
  assign set        = r_set;
  assign editing    = r_editing;
  assign field_sel  = r_field_sel;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl: directed vector table, hand-written
// corner sequences and random button activity against a behavioural model.
module tb_time_set_ctrl;

  localparam int HOLD = 5;
  localparam int REP  = 2;
  localparam int SLEN = 2;

  logic       clk, rst_n;
  logic       btn_mode, btn_cancel, btn_inc, btn_dec;
  logic [4:0] cur_hour;
  logic [5:0] cur_minute, cur_second;
  logic [4:0] set_hour;
  logic [5:0] set_minute, set_second;
  logic       set, editing;
  logic [1:0] field_sel;

  time_set_ctrl #(
    .HOUR_MAX(23), .MIN_MAX(59), .SEC_MAX(59),
    .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .SET_LEN(SLEN)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_mode(btn_mode), .btn_cancel(btn_cancel), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .cur_hour(cur_hour), .cur_minute(cur_minute), .cur_second(cur_second),
    .set_hour(set_hour), .set_minute(set_minute), .set_second(set_second),
    .set(set), .editing(editing), .field_sel(field_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [20:0] pack(input int h, input int m, input int s,
                                       input bit st, input bit ed, input int fs);
    return {5'(h), 6'(m), 6'(s), st, ed, 2'(fs)};
  endfunction

  function automatic logic [20:0] dut_word();
    return {set_hour, set_minute, set_second, set, editing, field_sel};
  endfunction

  // Behavioural model: 0=run, 1..3=editing hour/minute/second, 4=commit.
  int m_st, m_h, m_m, m_s, m_k, m_left;
  bit m_armed, pm, pc, pi, pd;

  function automatic int wrap(input int v, input int mx, input bit up);
    if (up) return (v >= mx) ? 0 : v + 1;
    return (v == 0 || v > mx) ? mx : v - 1;
  endfunction

  task automatic model_reset();
    m_st = 0; m_h = 0; m_m = 0; m_s = 0; m_k = 0; m_left = 0;
    m_armed = 0; pm = 0; pc = 0; pi = 0; pd = 0;
  endtask

  task automatic model_step(input bit mo, input bit ca, input bit in, input bit de);
    bit ev_m, ev_c, ev, do_step;
    ev_m = mo && !pm;
    ev_c = ca && !pc;
    do_step = 0;
    case (m_st)
      0: if (ev_m) begin m_h = cur_hour; m_m = cur_minute; m_s = cur_second; m_st = 1; end
      1, 2, 3: begin
        if (ev_c) begin
          m_st = 0; m_armed = 0;
        end else if (ev_m) begin
          m_armed = 0;
          if (m_st == 3) begin m_st = 4; m_left = SLEN; end
          else m_st++;
        end else if (in == de) begin
          m_armed = 0;
        end else begin
          ev = in ? !pi : !pd;
          if (ev) begin
            m_armed = 1; m_k = 0; do_step = 1;
          end else if (m_armed) begin
            m_k++;
            if (m_k >= HOLD && (m_k - HOLD) % REP == 0) do_step = 1;
          end
          if (do_step) begin
            if (m_st == 1) m_h = wrap(m_h, 23, in);
            else if (m_st == 2) m_m = wrap(m_m, 59, in);
            else m_s = wrap(m_s, 59, in);
          end
        end
      end
      default: begin
        m_left--;
        if (m_left == 0) m_st = 0;
      end
    endcase
    pm = mo; pc = ca; pi = in; pd = de;
  endtask

  function automatic logic [20:0] model_word();
    bit ed;
    ed = (m_st >= 1 && m_st <= 3);
    return pack(m_h, m_m, m_s, m_st == 4, ed, ed ? m_st : 0);
  endfunction

  task automatic apply(input bit mo, input bit ca, input bit in, input bit de);
    btn_mode = mo; btn_cancel = ca; btn_inc = in; btn_dec = de;
    @(posedge clk);
    #1;
    model_step(mo, ca, in, de);
    check("model", dut_word(), model_word());
  endtask

  task automatic set_cur(input int h, input int m, input int s);
    cur_hour = 5'(h); cur_minute = 6'(m); cur_second = 6'(s);
  endtask

  typedef struct {
    bit mo, ca, in, de;
    int eh, em, es;
    bit eset, eed;
    int efs;
  } vec_t;

  function automatic vec_t mk(input bit mo, input bit ca, input bit in, input bit de,
                              input int eh, input int em, input int es,
                              input bit eset, input bit eed, input int efs);
    vec_t v;
    v.mo = mo; v.ca = ca; v.in = in; v.de = de;
    v.eh = eh; v.em = em; v.es = es; v.eset = eset; v.eed = eed; v.efs = efs;
    return v;
  endfunction

  vec_t vecs[18];

  initial begin
    vecs[0]  = mk(0,0,0,0,  0, 0, 0, 0,0,0);
    vecs[1]  = mk(1,0,0,0, 13,45, 7, 0,1,1);
    vecs[2]  = mk(0,0,0,0, 13,45, 7, 0,1,1);
    vecs[3]  = mk(0,0,1,0, 14,45, 7, 0,1,1);
    vecs[4]  = mk(0,0,0,0, 14,45, 7, 0,1,1);
    vecs[5]  = mk(0,0,1,0, 15,45, 7, 0,1,1);
    vecs[6]  = mk(0,0,0,0, 15,45, 7, 0,1,1);
    vecs[7]  = mk(0,0,1,0, 16,45, 7, 0,1,1);
    vecs[8]  = mk(0,0,0,0, 16,45, 7, 0,1,1);
    vecs[9]  = mk(1,0,0,0, 16,45, 7, 0,1,2);
    vecs[10] = mk(0,0,0,0, 16,45, 7, 0,1,2);
    vecs[11] = mk(1,0,0,0, 16,45, 7, 0,1,3);
    vecs[12] = mk(0,0,0,0, 16,45, 7, 0,1,3);
    vecs[13] = mk(1,0,0,0, 16,45, 7, 1,0,0);
    vecs[14] = mk(0,0,0,0, 16,45, 7, 1,0,0);
    vecs[15] = mk(0,0,0,0, 16,45, 7, 0,0,0);
    vecs[16] = mk(0,1,1,0, 16,45, 7, 0,0,0);
    vecs[17] = mk(0,0,0,0, 16,45, 7, 0,0,0);

    model_reset();
    rst_n = 1'b0;
    btn_mode = 0; btn_cancel = 0; btn_inc = 0; btn_dec = 0;
    set_cur(0, 0, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    check("rst_set", set, 0);
    check("rst_editing", editing, 0);
    check("rst_field_sel", field_sel, 0);
    check("rst_values", {set_hour, set_minute, set_second}, 0);

    // Directed table: capture 13:45:07, three incs, commit.
    set_cur(13, 45, 7);
    for (int i = 0; i < 18; i++) begin
      apply(vecs[i].mo, vecs[i].ca, vecs[i].in, vecs[i].de);
      check($sformatf("vec%0d", i), dut_word(),
            pack(vecs[i].eh, vecs[i].em, vecs[i].es, vecs[i].eset, vecs[i].eed, vecs[i].efs));
    end

    // Wrap boundaries and auto-repeat.
    set_cur(0, 59, 0);
    apply(1,0,0,0); apply(0,0,0,1);
    check("hour_dec_wrap", set_hour, 23);
    apply(0,0,0,0); apply(1,0,0,0); apply(0,0,0,0);
    apply(0,0,1,0);
    check("min_inc_wrap", set_minute, 0);
    apply(0,0,0,0); apply(0,0,0,1);
    check("min_dec_wrap", set_minute, 59);
    apply(0,0,0,0); apply(1,0,0,0); apply(0,0,0,0);
    for (int i = 0; i < 10; i++) apply(0,0,1,0);
    check("sec_autorepeat", set_second, 4);
    for (int i = 0; i < 8; i++) apply(0,0,1,1);
    check("incdec_hold", set_second, 4);
    apply(0,0,0,0); apply(0,1,0,0);
    check("cancel_editing", editing, 0);
    check("cancel_keeps", set_second, 4);
    for (int i = 0; i < 3; i++) begin
      apply(0,0,0,0);
      check("cancel_no_set", set, 0);
    end

    // Cancel and mode edges together in EDIT_M.
    apply(1,0,0,0); apply(0,0,0,0); apply(1,0,0,0); apply(0,0,0,0);
    check("in_edit_m", field_sel, 2);
    apply(1,1,0,0);
    check("cancel_mode_prio", {editing, field_sel}, 0);
    apply(0,0,0,0);
    check("cancel_mode_noset", set, 0);

    // Corrupt captured values.
    set_cur(31, 63, 60);
    apply(1,0,0,0); apply(0,0,0,0); apply(0,0,1,0);
    check("corrupt_inc", set_hour, 0);
    apply(0,1,0,0); apply(0,0,0,0); apply(1,0,0,0); apply(0,0,0,0); apply(0,0,0,1);
    check("corrupt_dec", set_hour, 23);
    apply(0,0,0,0); apply(1,0,0,0); apply(0,0,0,0); apply(0,0,0,1);
    check("corrupt_min_dec", set_minute, 59);
    apply(0,0,0,0); apply(0,1,0,0); apply(0,0,0,0);

    // Held inc does not carry into the next field.
    set_cur(5, 10, 20);
    apply(1,0,0,0); apply(0,0,0,0); apply(0,0,1,0); apply(1,0,1,0);
    for (int i = 0; i < 12; i++) apply(0,0,1,0);
    check("no_carry_min", set_minute, 10);
    check("no_carry_hour", set_hour, 6);
    apply(0,0,0,0); apply(0,1,0,0); apply(0,0,0,0);

    // Asynchronous reset during the second COMMIT cycle.
    set_cur(1, 2, 3);
    apply(1,0,0,0); apply(0,0,0,0); apply(1,0,0,0); apply(0,0,0,0);
    apply(1,0,0,0); apply(0,0,0,0); apply(1,0,0,0);
    check("commit_set1", set, 1);
    apply(0,0,0,0);
    check("commit_set2", set, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_set", set, 0);
    model_reset();
    #2 rst_n = 1'b1;
    apply(0,0,0,0);
    check("post_reset", {set, editing, field_sel, set_hour}, 0);

    // Random button activity against the model.
    begin
      bit mo, ca, in, de;
      mo = 0; ca = 0; in = 0; de = 0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(9) == 0)  mo = !mo;
        if ($urandom_range(39) == 0) ca = !ca;
        if ($urandom_range(11) == 0) in = !in;
        if ($urandom_range(13) == 0) de = !de;
        if ($urandom_range(7) == 0)
          set_cur($urandom_range(31), $urandom_range(63), $urandom_range(63));
        else
          set_cur($urandom_range(23), $urandom_range(59), $urandom_range(59));
        apply(mo, ca, in, de);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- User-facing set-mode controller for the timer's hour/minute/second counters.
- Sequences a button-driven edit of hour, then minute, then second.
- Applies inc/dec with range wrap and auto-repeat.
- Commits the edited time by driving set_hour/set_minute/set_second and a stretched `set` pulse into the counter chain.

Parameters:
- HOUR_MAX, 23, last legal hour value; wraps to 0.
- MIN_MAX, 59, last legal minute value; wraps to 0.
- SEC_MAX, 59, last legal second value; wraps to 0.
- HOLD_CYCLES, 500, cycles inc/dec must stay high before auto-repeat starts (>=2).
- REPEAT_CYCLES, 100, cycles between auto-repeat steps (>=1).
- SET_LEN, 2, cycles `set` is held high on commit (>=1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- btn_mode  in  1  debounced level; rising edge advances state
- btn_cancel  in  1  debounced level; rising edge aborts edit
- btn_inc  in  1  debounced level; increment selected field
- btn_dec  in  1  debounced level; decrement selected field
- cur_hour  in  5  live hour from counter
- cur_minute  in  6  live minute from counter
- cur_second  in  6  live second from counter
- set_hour  out  5  edited hour, to counter
- set_minute  out  6  edited minute, to counter
- set_second  out  6  edited second, to counter
- set  out  1  load strobe to counters, SET_LEN cycles
- editing  out  1  high in any EDIT_* state
- field_sel  out  2  0=none, 1=hour, 2=minute, 3=second (display blink)

Behaviour:
- Reset (async, rst_n=0):
  - State RUN.
  - set=0, editing=0, field_sel=0.
  - set_hour/minute/second=0; edge-detect history = 0; repeat counters = 0.
- All buttons are rising-edge detected internally: registered previous level; event = level & ~prev.
- States: RUN, EDIT_H, EDIT_M, EDIT_S, COMMIT.
- RUN:
  - mode edge -> capture cur_* into set_* same edge -> EDIT_H.
  - inc/dec/cancel ignored.
- EDIT_H/EDIT_M/EDIT_S:
  - mode edge -> next state (H->M->S->COMMIT).
  - cancel edge -> RUN; set never asserted; set_* keep edited values.
- COMMIT:
  - set=1 for exactly SET_LEN cycles, then RUN.
  - set_* stable throughout COMMIT and 1 cycle after.
  - All buttons ignored in COMMIT.
- editing and field_sel are registered and track state with no extra lag: asserted in the cycle the state is entered.
- Inc/dec on the selected field only:
  - Step on the inc (dec) rising edge.
  - After the button has been high HOLD_CYCLES cycles, step again, then every REPEAT_CYCLES while held.
- Wrap rules:
  - inc at MAX -> 0; dec at 0 -> MAX.
  - Captured values > MAX (corrupt input): inc -> 0, dec -> MAX.
- Simultaneous events, priority cancel > mode > inc/dec:
  - inc and dec both high -> no step, and the repeat counter is cleared.
  - A mode or cancel edge clears the repeat counter; a held inc does not carry into the next field until it is released and re-pressed.
- Reset mid-COMMIT drops set immediately (async) and returns to RUN.
- Width: internal arithmetic in field width +1; no truncation artefacts.

Test Plan:
- Reset, then release: set=0, editing=0, field_sel=0, set_*=0.
- cur=13:45:07, mode edge -> EDIT_H, set_*=13/45/07. Three inc edges -> set_hour=16. Three mode edges -> set high exactly 2 cycles with 16:45:07, then RUN.
- EDIT_M with set_minute=59: inc -> 0. Dec -> 59. Hour=0: dec -> 23.
- Hold inc in EDIT_S (HOLD=5, REPEAT=2) for 10 cycles from 0: steps at cycles 0, 5, 7, 9 -> set_second=4.
- EDIT_M, cancel and mode edges in the same cycle -> RUN, set never asserted. Inc+dec held together -> value unchanged.
- Assert rst_n=0 during the second COMMIT cycle: set falls without a clock edge; state RUN after release.
